// File: rtl/dot_acc_pkg.sv
// Shared types and widths for the dot-product accumulator controller.
package dot_acc_pkg;

    localparam int OP_W   = 12;
    localparam int PROD_W = 24;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/dot_acc_ctrl_if.sv
// Operand-input and result-output handshakes of dot_acc_ctrl, grouped into one bundle.
interface dot_acc_ctrl_if
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/dot_acc_ctrl_chk.sv
// Handshake properties of dot_acc_ctrl: a held result never changes and
// inputs are never accepted while a result is pending.
module dot_acc_ctrl_chk #(
    parameter int ACC_W = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [ACC_W-1:0] out_sum
);

    a_no_accept_while_out: assert property (
        @(posedge clk) disable iff (rst) !(in_ready && out_valid)
    );

    a_result_held: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum))
    );

endmodule

// File: rtl/dot_acc_ctrl.sv
// Streams operand pairs through an external 12x12 multiplier and accumulates
// the products into one dot-product result per in_last-terminated burst.
module dot_acc_ctrl
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    dot_acc_ctrl_if.slave     bus,
    output logic [OP_W-1:0]   mul_x,
    output logic [OP_W-1:0]   mul_y,
    input  logic [PROD_W-1:0] mul_p
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              p_vld_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              fire_s;
    logic              handoff_s;
    logic [ACC_W:0]    prod_ext_s;
    logic [ACC_W:0]    sum_s;

    assign fire_s    = bus.in_valid & in_ready_q;
    assign handoff_s = out_valid_q & bus.out_ready;

    // Multiplier operands are gated so the multiplier sees zeros on idle cycles.
    always_comb begin
        mul_x = {OP_W{1'b0}};
        mul_y = {OP_W{1'b0}};
        if (fire_s) begin
            mul_x = bus.in_a;
            mul_y = bus.in_b;
        end else begin
            mul_x = {OP_W{1'b0}};
            mul_y = {OP_W{1'b0}};
        end
    end

    // Next accumulator, count and overflow; mul_p belongs to the pair fired last cycle.
    always_comb begin
        prod_ext_s                = {(ACC_W+1){1'b0}};
        prod_ext_s[PROD_W-1:0]    = mul_p;
        sum_s                     = {1'b0, acc_q} + prod_ext_s;
        acc_d                     = acc_q;
        cnt_d                     = cnt_q;
        ovf_d                     = ovf_q;
        if (handoff_s) begin
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
        end else if (p_vld_q) begin
            acc_d = sum_s[ACC_W-1:0];
            ovf_d = ovf_q | sum_s[ACC_W];
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // Control FSM with registered handshake outputs; reset wins over fire/handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_vld_q     <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            p_vld_q <= fire_s;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            case (state_q)
                ACC: begin
                    if (fire_s && bus.in_last) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                    end else begin
                        state_q    <= ACC;
                        in_ready_q <= 1'b1;
                    end
                    out_valid_q <= 1'b0;
                end
                FLUSH: begin
                    state_q     <= OUT;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (handoff_s) begin
                        state_q     <= ACC;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q     <= OUT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_acc_ctrl.sv
// Directed bench for dot_acc_ctrl with a behavioural one-cycle multiplier per instance.
module tb_dot_acc_ctrl;

    logic clk;
    logic rst;

    dot_acc_ctrl_if #(.ACC_W(32), .CNT_W(8)) if0 ();
    dot_acc_ctrl_if #(.ACC_W(24), .CNT_W(8)) if1 ();

    logic [11:0] mx0, my0, mx1, my1;
    logic [23:0] mp0, mp1;

    int n_checks;
    int n_errors;

    dot_acc_ctrl #(.ACC_W(32), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (if0.slave),
        .mul_x (mx0),
        .mul_y (my0),
        .mul_p (mp0)
    );

    dot_acc_ctrl #(.ACC_W(24), .CNT_W(8)) u_dut24 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if1.slave),
        .mul_x (mx1),
        .mul_y (my1),
        .mul_p (mp1)
    );

    dot_acc_ctrl_chk #(.ACC_W(32)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (if0.in_ready),
        .out_valid (if0.out_valid),
        .out_ready (if0.out_ready),
        .out_sum   (if0.out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency multiplier models, reset together with the DUTs.
    always @(posedge clk) begin
        if (rst) begin
            mp0 <= 24'd0;
            mp1 <= 24'd0;
        end else begin
            mp0 <= mx0 * my0;
            mp1 <= mx1 * my1;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [11:0] a, input logic [11:0] b, input logic last);
        @(negedge clk);
        if (sel) begin
            if1.in_valid = 1'b1; if1.in_a = a; if1.in_b = b; if1.in_last = last;
        end else begin
            if0.in_valid = 1'b1; if0.in_a = a; if0.in_b = b; if0.in_last = last;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        if0.in_valid = 1'b0; if0.in_last = 1'b0;
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
    endtask

    task automatic handoff(input bit sel);
        if (sel) if1.out_ready = 1'b1; else if0.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0;
        if0.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_a = 12'd0; if0.in_b = 12'd0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_a = 12'd0; if1.in_b = 12'd0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_in_ready", if0.in_ready, 1);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_out_sum", if0.out_sum, 0);
        check("rst_out_count", if0.out_count, 0);
        check("rst_out_ovf", if0.out_ovf, 0);
        check("rst24_in_ready", if1.in_ready, 1);

        // Three back-to-back pairs: 12 + 30 + 56 = 98.
        send(0, 12'd3, 12'd4, 1'b0);
        send(0, 12'd5, 12'd6, 1'b0);
        send(0, 12'd7, 12'd8, 1'b1);
        idle();
        check("b2b_t1_valid", if0.out_valid, 0);
        check("b2b_t1_ready", if0.in_ready, 0);
        @(negedge clk);
        check("b2b_t2_valid", if0.out_valid, 1);
        check("b2b_sum", if0.out_sum, 98);
        check("b2b_count", if0.out_count, 3);
        check("b2b_ovf", if0.out_ovf, 0);
        handoff(0);
        check("b2b_after_valid", if0.out_valid, 0);
        check("b2b_after_ready", if0.in_ready, 1);

        // Single max-value pair.
        send(0, 12'd4095, 12'd4095, 1'b1);
        idle();
        @(negedge clk);
        check("single_valid", if0.out_valid, 1);
        check("single_sum", if0.out_sum, 16769025);
        check("single_count", if0.out_count, 1);
        handoff(0);

        // Input gap between pairs: 2 + 12 = 14.
        send(0, 12'd1, 12'd2, 1'b0);
        idle();
        @(negedge clk);
        send(0, 12'd3, 12'd4, 1'b1);
        idle();
        @(negedge clk);
        check("gap_sum", if0.out_sum, 14);
        check("gap_count", if0.out_count, 2);
        handoff(0);

        // Backpressure with the next pair already offered.
        send(0, 12'd10, 12'd10, 1'b1);
        idle();
        @(negedge clk);
        check("bp_sum0", if0.out_sum, 100);
        if0.in_valid = 1'b1; if0.in_a = 12'd2; if0.in_b = 12'd2; if0.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", if0.out_valid, 1);
            check("bp_hold_sum", if0.out_sum, 100);
            check("bp_hold_ready", if0.in_ready, 0);
            check("bp_hold_mulx", mx0, 0);
        end
        handoff(0);
        check("bp_next_ready", if0.in_ready, 1);
        check("bp_next_mulx", mx0, 2);
        idle();
        check("bp_flush_valid", if0.out_valid, 0);
        @(negedge clk);
        check("bp_new_valid", if0.out_valid, 1);
        check("bp_new_sum", if0.out_sum, 4);
        check("bp_new_count", if0.out_count, 1);
        handoff(0);

        // Count saturation: 300 pairs of 1*1.
        for (int i = 0; i < 300; i++) begin
            send(0, 12'd1, 12'd1, (i == 299) ? 1'b1 : 1'b0);
        end
        idle();
        @(negedge clk);
        check("sat_sum", if0.out_sum, 300);
        check("sat_count", if0.out_count, 255);
        handoff(0);

        // 24-bit accumulator wraps: 2*16769025 - 2^24 = 16760834.
        send(1, 12'd4095, 12'd4095, 1'b0);
        send(1, 12'd4095, 12'd4095, 1'b1);
        idle();
        @(negedge clk);
        check("w24_valid", if1.out_valid, 1);
        check("w24_sum", if1.out_sum, 16760834);
        check("w24_ovf", if1.out_ovf, 1);
        check("w24_count", if1.out_count, 2);
        handoff(1);
        check("w24_cleared_ovf", if1.out_ovf, 0);

        // Reset during FLUSH discards the result.
        send(0, 12'd5, 12'd5, 1'b1);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstfl_valid", if0.out_valid, 0);
        check("rstfl_ready", if0.in_ready, 1);
        check("rstfl_sum", if0.out_sum, 0);
        @(negedge clk);
        check("rstfl_no_late_valid", if0.out_valid, 0);
        send(0, 12'd1, 12'd1, 1'b1);
        idle();
        @(negedge clk);
        check("rstfl_new_valid", if0.out_valid, 1);
        check("rstfl_new_sum", if0.out_sum, 1);
        check("rstfl_new_count", if0.out_count, 1);
        handoff(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_acc_ctrl.md
DOT_ACC_CTRL -- requirements
Module: dot_acc_ctrl

Interface
REQ-001 Parameter: ACC_W, default 32, accumulator/result width (min 24).
REQ-002 Parameter: CNT_W, default 8, product-count width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair a/b is offered.
REQ-006 in_ready  out  1  block accepts a pair this cycle; fire = in_valid & in_ready.
REQ-007 in_a  in  12  unsigned multiplicand.
REQ-008 in_b  in  12  unsigned multiplier.
REQ-009 in_last  in  1  marks the final pair of a dot product; sampled on fire.
REQ-010 mul_x  out  12  operand to the external 12x12 multiplier.
REQ-011 mul_y  out  12  operand to the external 12x12 multiplier.
REQ-012 mul_p  in  24  multiplier product; equals the product of the mul_x/mul_y driven one cycle earlier.
REQ-013 out_valid  out  1  dot-product result is available.
REQ-014 out_ready  in  1  downstream takes the result; handoff = out_valid & out_ready.
REQ-015 out_sum  out  ACC_W  accumulated sum of products, modulo 2^ACC_W.
REQ-016 out_count  out  CNT_W  number of pairs in this dot product, saturating at 2^CNT_W-1.
REQ-017 out_ovf  out  1  sticky flag: a carry out of bit ACC_W-1 occurred during this dot product.

Function
REQ-018 FSM states: ACC (accept pairs), FLUSH (final product in flight), OUT (result held).
REQ-019 in_ready = 1 only in ACC.
REQ-020 mul_x/mul_y = in_a/in_b when fire, else 0 (combinational).
REQ-021 A 1-bit register p_vld <= fire, every cycle.
REQ-022 When p_vld=1: acc <= acc + mul_p, zero-extended to ACC_W; the carry out sets ovf; cnt increments and saturates.
REQ-023 ACC: fire with in_last=1 -> FLUSH; fire with in_last=0 or no fire -> stay in ACC; in_valid gaps are allowed.
REQ-024 FLUSH: lasts exactly one cycle, in which the final product is added -> OUT.
REQ-025 OUT: out_valid=1; out_sum/out_count/out_ovf = acc/cnt/ovf and stay stable until handoff.
REQ-026 Handoff in OUT clears acc, cnt and ovf, and moves to ACC; in_ready=1 in the next cycle.
REQ-027 Latency: fire of the last pair in cycle t -> out_valid=1 in cycle t+2.
REQ-028 A dot product of one pair (in_last on its first fire) is legal.
REQ-029 out_valid is 0 outside OUT; outputs not in OUT are don't-care except out_valid.

Reset
REQ-030 rst=1 at a clock edge sets: state=ACC, acc=0, cnt=0, ovf=0, p_vld=0.
REQ-031 After reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
REQ-032 rst in any state, including FLUSH or OUT, discards the partial or held result; no out_valid follows.
REQ-033 rst overrides a simultaneous fire or handoff.

Structure
REQ-034 Shared package dot_acc_pkg: state enum {ACC, FLUSH, OUT}, OP_W=12, PROD_W=24.
REQ-035 No internal sub-module; the Wallace12x12 multiplier connects via mul_* at the parent, with its rst tied to the same rst.

Verification
REQ-036 Reset: -> in_ready=1, out_valid=0, out_sum=0, out_count=0.
REQ-037 Pairs (3,4),(5,6),(7,8,last) back-to-back -> out_valid two cycles after the last fire; out_sum=98, out_count=3, out_ovf=0.
REQ-038 Single pair (4095,4095,last) -> out_sum=16769025, out_count=1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_sum stable, in_ready=0; on handoff, the next cycle has in_ready=1 and a new pair (2,2,last) gives out_sum=4.
REQ-040 ACC_W=24, pairs (4095,4095),(4095,4095,last) -> out_sum=16760834, out_ovf=1.
REQ-041 rst asserted during FLUSH -> next cycle state ACC, out_valid=0, and the following dot product (1,1,last) gives out_sum=1.
